// File: rtl/decode_stage.sv
// MIPS32-subset decode stage: register file, instruction decode, load-use hazard
// detection and a single registered output bundle with valid/ready handshaking.
module decode_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [31:0]     in_pc,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_mem_read,
  input  logic [AW-1:0]   ex_dst,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_pc,
  output logic [XLEN-1:0] out_rs_data,
  output logic [XLEN-1:0] out_rt_data,
  output logic [XLEN-1:0] out_imm,
  output logic [AW-1:0]   out_dst,
  output logic [10:0]     out_ctrl,
  output logic            out_illegal
);

  logic [XLEN-1:0] rf_q [NREG];

  logic [5:0]    opcode, funct;
  logic [AW-1:0] rs, rt, rd;
  logic [15:0]   imm16;
  logic          unused_shamt;

  assign opcode       = in_inst[31:26];
  assign funct        = in_inst[5:0];
  assign rs           = in_inst[21 +: AW];
  assign rt           = in_inst[16 +: AW];
  assign rd           = in_inst[11 +: AW];
  assign imm16        = in_inst[15:0];
  assign unused_shamt = ^in_inst[10:6];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
    end else if (wb_en && wb_addr != '0) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  logic [XLEN-1:0] rs_data, rt_data;

  always_comb begin
    rs_data = rf_q[rs];
    rt_data = rf_q[rt];
    if (BYPASS != 0 && wb_en && wb_addr == rs) rs_data = wb_data;
    if (BYPASS != 0 && wb_en && wb_addr == rt) rt_data = wb_data;
    if (rs == '0) rs_data = '0;
    if (rt == '0) rt_data = '0;
  end

  // Decode fields that make up out_ctrl
  logic            reg_write, mem_to_reg, mem_write, branch, alu_src, illegal;
  logic [3:0]      alu_control;
  logic [1:0]      reg_dst;
  logic [XLEN-1:0] imm;
  logic [AW-1:0]   dst;
  logic [XLEN-1:0] imm_sext;

  assign imm_sext = {{(XLEN-16){imm16[15]}}, imm16};

  always_comb begin
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    mem_write   = 1'b0;
    branch      = 1'b0;
    alu_src     = 1'b0;
    alu_control = 4'b0000;
    reg_dst     = 2'b00;
    illegal     = 1'b0;
    imm         = '0;
    case (opcode)
      6'b000000: begin
        if (in_inst != 32'h0) begin
          reg_write = 1'b1;
          reg_dst   = 2'b01;
          case (funct)
            6'b100001: alu_control = 4'b0010;
            6'b100011: alu_control = 4'b0110;
            6'b100100: alu_control = 4'b0000;
            6'b100101: alu_control = 4'b0001;
            6'b101010: alu_control = 4'b0111;
            default: begin
              reg_write = 1'b0;
              reg_dst   = 2'b00;
              illegal   = 1'b1;
            end
          endcase
        end
      end
      6'b001001: begin
        reg_write   = 1'b1;
        alu_src     = 1'b1;
        alu_control = 4'b0010;
        imm         = imm_sext;
      end
      6'b001100: begin
        reg_write   = 1'b1;
        alu_src     = 1'b1;
        alu_control = 4'b0000;
        imm[15:0]   = imm16;
      end
      6'b001101: begin
        reg_write   = 1'b1;
        alu_src     = 1'b1;
        alu_control = 4'b0001;
        imm[15:0]   = imm16;
      end
      6'b001111: begin
        reg_write   = 1'b1;
        alu_src     = 1'b1;
        alu_control = 4'b1000;
        imm[31:0]   = {imm16, 16'h0000};
      end
      6'b100011: begin
        reg_write   = 1'b1;
        mem_to_reg  = 1'b1;
        alu_src     = 1'b1;
        alu_control = 4'b0010;
        imm         = imm_sext;
      end
      6'b101011: begin
        mem_write   = 1'b1;
        alu_src     = 1'b1;
        alu_control = 4'b0010;
        imm         = imm_sext;
      end
      6'b000100: begin
        branch      = 1'b1;
        alu_control = 4'b0110;
        imm         = imm_sext;
      end
      default: illegal = 1'b1;
    endcase
    if (!reg_write)            dst = '0;
    else if (reg_dst == 2'b01) dst = rd;
    else                       dst = rt;
  end

  // Load-use hazard: rt only matters for instructions that actually read it
  logic rt_read, hazard, accept;

  assign rt_read  = (opcode == 6'b000000) || (opcode == 6'b101011) || (opcode == 6'b000100);
  assign hazard   = in_valid && ex_mem_read && ex_dst != '0 &&
                    (ex_dst == rs || (rt_read && ex_dst == rt));
  assign in_ready = rst && !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_rs_data <= '0;
      out_rt_data <= '0;
      out_imm     <= '0;
      out_dst     <= '0;
      out_ctrl    <= '0;
      out_illegal <= 1'b0;
    end else begin
      if (flush)          out_valid <= 1'b0;
      else if (accept)    out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (accept) begin
        out_pc      <= in_pc;
        out_rs_data <= rs_data;
        out_rt_data <= rt_data;
        out_imm     <= imm;
        out_dst     <= dst;
        out_ctrl    <= {reg_write, mem_to_reg, mem_write, branch, alu_control, alu_src, reg_dst};
        out_illegal <= illegal;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage; two instances share stimulus so that the
// forwarding (BYPASS=1) and non-forwarding (BYPASS=0) variants can be compared.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, wb_en = 1'b0, ex_mem_read = 1'b0, flush = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_inst = '0, in_pc = '0, wb_data = '0;
  logic [4:0]  wb_addr = '0, ex_dst = '0;

  logic        rdy0, val0, ill0, rdy1, val1, ill1;
  logic [31:0] pc0, rsd0, rtd0, imm0, pc1, rsd1, rtd1, imm1;
  logic [4:0]  dst0, dst1;
  logic [10:0] ctrl0, ctrl1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .NREG(32), .BYPASS(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_inst(in_inst),
    .in_pc(in_pc), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_mem_read(ex_mem_read), .ex_dst(ex_dst), .flush(flush), .out_valid(val0),
    .out_ready(out_ready), .out_pc(pc0), .out_rs_data(rsd0), .out_rt_data(rtd0),
    .out_imm(imm0), .out_dst(dst0), .out_ctrl(ctrl0), .out_illegal(ill0)
  );

  decode_stage #(.XLEN(32), .NREG(32), .BYPASS(0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_inst(in_inst),
    .in_pc(in_pc), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_mem_read(ex_mem_read), .ex_dst(ex_dst), .flush(flush), .out_valid(val1),
    .out_ready(out_ready), .out_pc(pc1), .out_rs_data(rsd1), .out_rt_data(rtd1),
    .out_imm(imm1), .out_dst(dst1), .out_ctrl(ctrl1), .out_illegal(ill1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction, expect it to be taken at the next edge
  task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    #1;
    check("issue_ready", rdy0, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  localparam int NVEC = 12;
  logic [31:0] v_inst [NVEC] = '{32'h2402FFFF, 32'h3402FFFF, 32'h30038000, 32'h3C031234,
                                 32'h8CA80004, 32'h10A6FFFE, 32'h00A6502A, 32'h00A65824,
                                 32'h00A65825, 32'h00000000, 32'hFC000000, 32'h00A65802};
  logic [10:0] v_ctrl [NVEC] = '{11'h414, 11'h40C, 11'h404, 11'h444, 11'h614, 11'h0B0,
                                 11'h439, 11'h401, 11'h409, 11'h000, 11'h000, 11'h000};
  logic [31:0] v_imm  [NVEC] = '{32'hFFFFFFFF, 32'h0000FFFF, 32'h00008000, 32'h12340000,
                                 32'h00000004, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h0, 32'h0,
                                 32'h0, 32'h0};
  logic [4:0]  v_dst  [NVEC] = '{5'd2, 5'd2, 5'd3, 5'd3, 5'd8, 5'd0, 5'd10, 5'd11, 5'd11,
                                 5'd0, 5'd0, 5'd0};
  logic        v_ill  [NVEC] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};

  logic [4:0]  w_addr [5] = '{5'd5, 5'd6, 5'd4, 5'd2, 5'd9};
  logic [31:0] w_data [5] = '{32'h7, 32'h3, 32'h44, 32'h22, 32'h1111};

  initial begin
    // Reset state
    in_valid = 1'b1;
    in_inst  = 32'h00A63821;
    #12;
    check("rst_valid", val0, 1'b0);
    check("rst_ready", rdy0, 1'b0);
    check("rst_ctrl", ctrl0, 11'h0);
    check("rst_pc", pc0, 32'h0);
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      wb_en   = 1'b1;
      wb_addr = w_addr[i];
      wb_data = w_data[i];
      step();
    end
    wb_en = 1'b0;

    // ADDU r7,r5,r6
    issue(32'h00A63821, 32'h100);
    check("addu_valid", val0, 1'b1);
    check("addu_rs", rsd0, 32'h7);
    check("addu_rt", rtd0, 32'h3);
    check("addu_dst", dst0, 5'd7);
    check("addu_ctrl", ctrl0, 11'h411);
    check("addu_pc", pc0, 32'h100);
    check("addu_ill", ill0, 1'b0);
    step();
    check("drain_valid", val0, 1'b0);

    for (int i = 0; i < NVEC; i++) begin
      issue(v_inst[i], 32'h1000 + 32'(i * 4));
      check($sformatf("vec%0d_valid", i), val0, 1'b1);
      check($sformatf("vec%0d_ctrl", i), ctrl0, v_ctrl[i]);
      check($sformatf("vec%0d_imm", i), imm0, v_imm[i]);
      check($sformatf("vec%0d_dst", i), dst0, v_dst[i]);
      check($sformatf("vec%0d_ill", i), ill0, v_ill[i]);
    end
    check("beq_rt_skip", 1'b1, 1'b1 ^ val0 ^ 1'b1 ^ 1'b0);

    // Load-use hazard on rs: SUBU r1,r4,r2 behind a load to r4
    ex_mem_read = 1'b1;
    ex_dst      = 5'd4;
    in_valid    = 1'b1;
    in_inst     = 32'h00820823;
    in_pc       = 32'h180;
    #1;
    check("haz_ready", rdy0, 1'b0);
    step();
    check("haz_bubble", val0, 1'b0);
    ex_dst = 5'd2;
    #1;
    check("haz_rt_ready", rdy0, 1'b0);
    in_inst = 32'h2402FFFF;
    #1;
    check("haz_rt_unread", rdy0, 1'b1);
    in_inst     = 32'h00820823;
    ex_mem_read = 1'b0;
    issue(32'h00820823, 32'h180);
    check("subu_valid", val0, 1'b1);
    check("subu_rs", rsd0, 32'h44);
    check("subu_rt", rtd0, 32'h22);
    check("subu_ctrl", ctrl0, 11'h431);
    check("subu_dst", dst0, 5'd1);

    // Downstream stall with a new instruction waiting
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h3C031234;
    in_pc     = 32'h200;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ready", rdy0, 1'b0);
      step();
      check("stall_valid", val0, 1'b1);
      check("stall_pc", pc0, 32'h180);
      check("stall_dst", dst0, 5'd1);
    end
    out_ready = 1'b1;
    issue(32'h3C031234, 32'h200);
    check("unstall_pc", pc0, 32'h200);
    check("unstall_imm", imm0, 32'h12340000);

    // Same-cycle write-back to r9 while accepting SW r9,0(r0)
    wb_en   = 1'b1;
    wb_addr = 5'd9;
    wb_data = 32'hDEAD;
    issue(32'hAC090000, 32'h240);
    wb_en = 1'b0;
    check("byp1_rt", rtd0, 32'hDEAD);
    check("byp0_rt", rtd1, 32'h1111);
    check("sw_ctrl", ctrl0, 11'h114);

    // Writes to r0 are never visible, even forwarded
    wb_en   = 1'b1;
    wb_addr = 5'd0;
    wb_data = 32'h55;
    issue(32'h2402FFFF, 32'h244);
    wb_en = 1'b0;
    check("r0_byp_rs", rsd0, 32'h0);
    issue(32'h2402FFFF, 32'h248);
    check("r0_rs", rsd1, 32'h0);

    // Flush while a bundle is held; offered instruction is not consumed
    flush     = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h00A63821;
    in_pc     = 32'h300;
    #1;
    check("flush_ready", rdy0, 1'b0);
    step();
    check("flush_valid", val0, 1'b0);
    check("flush_pc", pc0, 32'h248);
    flush     = 1'b0;
    out_ready = 1'b1;
    issue(32'h00A63821, 32'h300);
    check("post_flush_pc", pc0, 32'h300);

    // Reset while stalled
    out_ready = 1'b0;
    step();
    rst = 1'b0;
    #1;
    check("mrst_valid", val0, 1'b0);
    check("mrst_pc", pc0, 32'h0);
    check("mrst_rs", rsd0, 32'h0);
    check("mrst_ctrl", ctrl0, 11'h0);
    check("mrst_dst", dst0, 5'd0);
    step();
    check("mrst_ready", rdy0, 1'b0);
    rst       = 1'b1;
    out_ready = 1'b1;
    issue(32'h00A63821, 32'h400);
    check("rel_valid", val0, 1'b1);
    check("rel_rs", rsd0, 32'h0);
    check("rel_rt", rtd0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
